// File: rtl/score_recorder.sv
// Live key-press recorder: measures note/rest lengths in beat ticks, quantises
// them to duration codes and streams {code, pitch} words into a score RAM.
module score_recorder #(
  parameter int NOTE_W = 5,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beat_tick,
  input  logic                rec_start,
  input  logic                rec_stop,
  input  logic                key_valid,
  input  logic [NOTE_W-1:0]   key_code,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [NOTE_W+2:0]   wr_data,
  output logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                full
);

  typedef enum logic [1:0] {IDLE, ARMED, NOTE, REST} state_t;

  state_t              state_reg, state_next;
  logic [5:0]          cnt_reg, cnt_next;
  logic [NOTE_W-1:0]   pitch_reg, pitch_next;
  logic                wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [NOTE_W+2:0]   wr_data_reg, wr_data_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                busy_reg, busy_next;
  logic                full_reg, full_next;

  logic                emit;
  logic [NOTE_W-1:0]   emit_pitch;
  logic [ADDR_W-1:0]   addr_eff;
  logic [5:0]          cnt_inc;
  logic [5:0]          cnt_open;

  function automatic logic [2:0] quantise(input logic [5:0] c);
    if (c <= 6'd1)       return 3'd0;
    else if (c == 6'd2)  return 3'd1;
    else if (c <= 6'd5)  return 3'd2;
    else if (c <= 6'd11) return 3'd3;
    else if (c <= 6'd19) return 3'd4;
    else if (c <= 6'd27) return 3'd5;
    else                 return 3'd6;
  endfunction

  // The address advances in the cycle after a write, so a write issued while
  // the previous one is still on the bus must target the following address.
  assign addr_eff = wr_en_reg ? wr_addr_reg + ADDR_W'(1) : wr_addr_reg;
  assign cnt_inc  = (beat_tick && cnt_reg != 6'd63) ? cnt_reg + 6'd1 : cnt_reg;
  assign cnt_open = {5'd0, beat_tick};

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pitch_next   = pitch_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = addr_eff;
    wr_data_next = wr_data_reg;
    count_next   = count_reg + {{ADDR_W{1'b0}}, wr_en_reg};
    full_next    = full_reg;
    emit         = 1'b0;
    emit_pitch   = '0;

    if (rec_start) begin
      state_next   = ARMED;
      cnt_next     = '0;
      wr_addr_next = '0;
      count_next   = '0;
      full_next    = 1'b0;
    end else begin
      case (state_reg)
        ARMED: begin
          if (rec_stop) begin
            state_next = IDLE;
          end else if (key_valid) begin
            state_next = NOTE;
            cnt_next   = cnt_open;
            pitch_next = key_code;
          end
        end
        NOTE: begin
          emit_pitch = pitch_reg;
          if (rec_stop) begin
            emit       = 1'b1;
            state_next = IDLE;
          end else if (!key_valid) begin
            emit       = 1'b1;
            state_next = REST;
            cnt_next   = cnt_open;
          end else if (key_code != pitch_reg) begin
            emit       = 1'b1;
            pitch_next = key_code;
            cnt_next   = cnt_open;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        REST: begin
          if (rec_stop) begin
            emit       = (cnt_reg != 6'd0);
            state_next = IDLE;
          end else if (key_valid) begin
            emit       = (cnt_reg != 6'd0);
            state_next = NOTE;
            pitch_next = key_code;
            cnt_next   = cnt_open;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: ;
      endcase
    end

    if (emit) begin
      wr_en_next   = 1'b1;
      wr_data_next = {quantise(cnt_reg), emit_pitch};
      // Filling the last slot ends the take; whatever segment just opened is dropped.
      if (&addr_eff) begin
        full_next  = 1'b1;
        state_next = IDLE;
      end
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pitch_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      full_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pitch_reg   <= pitch_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      count_reg   <= count_next;
      busy_reg    <= busy_next;
      full_reg    <= full_next;
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign word_count = count_reg;
  assign busy       = busy_reg;
  assign full       = full_reg;

endmodule
